// File: rtl/iter_mul_ctrl.sv
// iter_mul_ctrl: RV32M multiply sequencer for the execute stage.
// Runs a 32-iteration shift-add on operand magnitudes, applies the sign
// at the end, and returns the selected 32-bit half with a one-cycle done.
module iter_mul_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            startE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] rdata1E,
   input  logic [XLEN-1:0] rdata2E,
   input  logic [4:0]      waddrE,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      waddr_out,
   output logic            reset_hold_start
);

   localparam int PW = 2 * XLEN;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0] mplier_q, mplier_d;
   logic [4:0]      cnt_q, cnt_d;
   logic            neg_q, neg_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      waddr_q, waddr_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            accept;
   logic            signed1, signed2;
   logic            sign1, sign2;
   logic [XLEN-1:0] abs1, abs2;
   logic [PW-1:0]   sum;
   logic [PW-1:0]   prod;

   // Operand preparation, accept decode and the datapath step for one iteration
   always_comb begin
      accept  = (state_q == S_IDLE) && startE && !funct3E[2];
      // MULH: both signed; MULHSU: rs1 signed only; MUL/MULHU: unsigned
      signed1 = (funct3E == 3'b001) || (funct3E == 3'b010);
      signed2 = (funct3E == 3'b001);
      sign1   = signed1 && rdata1E[XLEN-1];
      sign2   = signed2 && rdata2E[XLEN-1];
      // Magnitude of the most negative value wraps to itself, which is
      // exactly its unsigned magnitude.
      abs1    = sign1 ? (~rdata1E + {{(XLEN-1){1'b0}}, 1'b1}) : rdata1E;
      abs2    = sign2 ? (~rdata2E + {{(XLEN-1){1'b0}}, 1'b1}) : rdata2E;
      sum     = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
      prod    = neg_q ? (~sum + {{(PW-1){1'b0}}, 1'b1}) : sum;
   end

   // Next-state and next-register values for the sequencer
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      funct3_d = funct3_q;
      result_d = result_q;
      waddr_d  = waddr_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d    = {PW{1'b0}};
               mcand_d  = {{XLEN{1'b0}}, abs1};
               mplier_d = abs2;
               cnt_d    = 5'd0;
               neg_d    = sign1 ^ sign2;
               funct3_d = funct3E;
               waddr_d  = waddrE;
               if ((rdata1E == {XLEN{1'b0}}) || (rdata2E == {XLEN{1'b0}})) begin
                  // Product is zero: skip the iterations entirely
                  result_d = {XLEN{1'b0}};
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               // Last iteration: sign-correct the final sum and pick the half
               result_d = (funct3_q == 3'b000) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_BUSY);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers; reset discards any in-flight operation
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         acc_q    <= {PW{1'b0}};
         mcand_q  <= {PW{1'b0}};
         mplier_q <= {XLEN{1'b0}};
         cnt_q    <= 5'd0;
         neg_q    <= 1'b0;
         funct3_q <= 3'b000;
         result_q <= {XLEN{1'b0}};
         waddr_q  <= 5'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         funct3_q <= funct3_d;
         result_q <= result_d;
         waddr_q  <= waddr_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Stall covers the start cycle combinationally, then every iteration
   assign stall            = accept || (state_q == S_BUSY);
   assign busy             = busy_q;
   assign done             = done_q;
   assign reset_hold_start = done_q;
   assign result           = result_q;
   assign waddr_out        = waddr_q;

endmodule

// File: tb/tb_iter_mul_ctrl.sv
// Testbench for iter_mul_ctrl: scoreboard of expected results, per-feature tasks.
module tb_iter_mul_ctrl;

   logic        clk;
   logic        rst;
   logic        startE;
   logic [2:0]  funct3E;
   logic [31:0] rdata1E;
   logic [31:0] rdata2E;
   logic [4:0]  waddrE;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  waddr_out;
   logic        reset_hold_start;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  wa;
   } exp_t;

   exp_t sb[$];
   int checks   = 0;
   int failures = 0;

   iter_mul_ctrl #(.XLEN(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .startE           (startE),
      .funct3E          (funct3E),
      .rdata1E          (rdata1E),
      .rdata2E          (rdata2E),
      .waddrE           (waddrE),
      .stall            (stall),
      .busy             (busy),
      .done             (done),
      .result           (result),
      .waddr_out        (waddr_out),
      .reset_hold_start (reset_hold_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference product from wide signed arithmetic
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [65:0] ea;
      logic signed [65:0] eb;
      logic signed [65:0] p;
      ea = (f3 == 3'b001 || f3 == 3'b010) ? {{34{a[31]}}, a} : {34'b0, a};
      eb = (f3 == 3'b001) ? {{34{b[31]}}, b} : {34'b0, b};
      p  = ea * eb;
      return (f3 == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   // Issue one multiply at the current negedge and follow it to completion.
   // inject_k >= 0 pulses a stray startE in the cycle after edge E_inject_k.
   task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa,
                         input logic [31:0] exp_res, input int inject_k);
      exp_t e;
      exp_t got;
      int   busy_n;
      int   done_k;
      int   stall_bad;
      int   exp_lat;
      e.res = exp_res;
      e.wa  = wa;
      sb.push_back(e);
      exp_lat = (a == 32'd0 || b == 32'd0) ? 0 : 32;
      startE  = 1'b1;
      funct3E = f3;
      rdata1E = a;
      rdata2E = b;
      waddrE  = wa;
      #1;
      checks++;
      if (stall !== 1'b1)
         $display("FAIL %s start_stall got=%b want=1", name, stall);
      if (stall !== 1'b1) failures++;
      @(posedge clk);
      @(negedge clk);
      busy_n    = 0;
      done_k    = -1;
      stall_bad = 0;
      for (int k = 0; k < 40 && done_k < 0; k++) begin
         startE  = (k == inject_k);
         funct3E = 3'b000;
         rdata1E = $urandom | 32'd1;
         rdata2E = $urandom | 32'd1;
         waddrE  = ~wa;
         #1;
         if (busy === 1'b1) busy_n++;
         if (stall !== (busy === 1'b1)) stall_bad++;
         if (reset_hold_start !== done) stall_bad++;
         if (done === 1'b1) done_k = k;
         @(negedge clk);
      end
      startE = 1'b0;
      got = sb.pop_front();
      checks++;
      if (done_k != exp_lat) begin
         failures++;
         $display("FAIL %s done_cycle got=%0d want=%0d", name, done_k, exp_lat);
      end
      checks++;
      if (busy_n != exp_lat) begin
         failures++;
         $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy_n, exp_lat);
      end
      checks++;
      if (stall_bad != 0) begin
         failures++;
         $display("FAIL %s stall_or_hold_mismatch got=%0d want=0", name, stall_bad);
      end
      checks++;
      if (result !== got.res) begin
         failures++;
         $display("FAIL %s result got=%h want=%h", name, result, got.res);
      end
      checks++;
      if (waddr_out !== got.wa) begin
         failures++;
         $display("FAIL %s waddr_out got=%0d want=%0d", name, waddr_out, got.wa);
      end
      // One cycle later: back in IDLE, pulse over, result held
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== got.res) begin
         failures++;
         $display("FAIL %s after_done done=%b busy=%b result=%h want 0 0 %h",
                  name, done, busy, result, got.res);
      end
      $display("op %s f3=%b a=%h b=%h result=%h waddr=%0d lat=%0d", name, f3, a, b,
               result, waddr_out, done_k);
   endtask

   task automatic test_reset();
      rst = 1'b1; startE = 1'b0; funct3E = 3'b000;
      rdata1E = 32'd0; rdata2E = 32'd0; waddrE = 5'd0;
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({stall, busy, done, reset_hold_start, result, waddr_out} !== 41'd0) begin
         failures++;
         $display("FAIL reset_state got=%h want=0",
                  {stall, busy, done, reset_hold_start, result, waddr_out});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      $display("reset released");
   endtask

   task automatic test_basic();
      run_op("mul_7x6", 3'b000, 32'd7, 32'd6, 5'd5, 32'd42, -1);
   endtask

   task automatic test_signed_mix();
      run_op("mul_m1x2",    3'b000, 32'hFFFFFFFF, 32'd2, 5'd1, 32'hFFFFFFFE, -1);
      run_op("mulh_m1x2",   3'b001, 32'hFFFFFFFF, 32'd2, 5'd2, 32'hFFFFFFFF, -1);
      run_op("mulhu_max",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, -1);
   endtask

   task automatic test_corners();
      run_op("mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, -1);
      run_op("mulhsu_min_max",3'b010, 32'h80000000, 32'hFFFFFFFF, 5'd6, 32'h80000000, -1);
      run_op("mulhsu_m1_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFF, -1);
   endtask

   task automatic test_zero_fast();
      run_op("mul_zero", 3'b000, 32'd0, 32'h1234, 5'd8, 32'd0, -1);
   endtask

   task automatic test_ignored_start();
      int seen_done;
      run_op("mul_inject", 3'b000, 32'd1000, 32'd1001, 5'd9, 32'd1001000, 10);
      // Divide encodings are never accepted
      startE  = 1'b1;
      funct3E = 3'b100;
      rdata1E = 32'd5;
      rdata2E = 32'd6;
      waddrE  = 5'd12;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL div_stall got=%b want=0", stall);
      end
      seen_done = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) seen_done++;
      end
      startE = 1'b0;
      checks++;
      if (seen_done != 0) begin
         failures++;
         $display("FAIL div_ignored activity_cycles got=%0d want=0", seen_done);
      end
      $display("div request ignored, active cycles=%0d", seen_done);
   endtask

   task automatic test_reset_mid_busy();
      int bad;
      startE  = 1'b1;
      funct3E = 3'b000;
      rdata1E = 32'd11;
      rdata2E = 32'd13;
      waddrE  = 5'd20;
      @(posedge clk);
      @(negedge clk);
      startE = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({stall, busy, done, reset_hold_start, result, waddr_out} !== 41'd0) begin
         failures++;
         $display("FAIL reset_mid_busy got=%h want=0",
                  {stall, busy, done, reset_hold_start, result, waddr_out});
      end
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      rst = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL reset_discard stray_cycles got=%0d want=0", bad);
      end
      $display("reset mid-busy, stray cycles=%0d", bad);
      run_op("mul_3x5_after_reset", 3'b000, 32'd3, 32'd5, 5'd10, 32'd15, -1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f3;
      for (int i = 0; i < 6; i++) begin
         a  = $urandom;
         b  = $urandom;
         f3 = 3'(i % 4);
         run_op("rand_b2b", f3, a, b, 5'(i + 14), model(f3, a, b), -1);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_left got=%0d want=0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed_mix();
      test_corners();
      test_zero_fast();
      test_ignored_start();
      test_reset_mid_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
